// File: rtl/janela_pkg.sv
// janela_pkg: shared constants and types for the 3x3 window generator
package janela_pkg;
  localparam int PIX_W_DEF = 9;
  localparam int WIN_N = 9;
  typedef logic [PIX_W_DEF-1:0] pixel_t;
  typedef pixel_t [0:WIN_N-1] janela_t;
endpackage

// File: rtl/linha_atraso.sv
// linha_atraso: IMG_W-deep, PIX_W-wide delay line advancing only when enabled
module linha_atraso
  import janela_pkg::*;
#(
  parameter int IMG_W = 16,
  parameter int PIX_W = PIX_W_DEF
) (
  input  logic             clk,
  input  logic             en_i,
  input  logic [PIX_W-1:0] d_i,
  output logic [PIX_W-1:0] q_o
);
  logic [PIX_W-1:0] mem_q [IMG_W];
  // shift one slot per accepted pixel; contents need no reset since validity is gated by the counters
  always_ff @(posedge clk) begin
    if (en_i) begin
      mem_q[0] <= d_i;
      for (int i = 1; i < IMG_W; i++) mem_q[i] <= mem_q[i-1];
    end
  end
  assign q_o = mem_q[IMG_W-1];
endmodule

// File: rtl/janela_3x3.sv
// janela_3x3: streaming 3x3 window generator; optional end-of-frame flag via JANELA_FIM_QUADRO_EN
module janela_3x3
  import janela_pkg::*;
#(
  parameter int PIX_W = PIX_W_DEF,
  parameter int IMG_W = 16,
  parameter int IMG_H = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pix_valid,
  input  logic [PIX_W-1:0] pix_in,
  output logic             win_valid,
  output logic [PIX_W-1:0] n1,
  output logic [PIX_W-1:0] n2,
  output logic [PIX_W-1:0] n3,
  output logic [PIX_W-1:0] n4,
  output logic [PIX_W-1:0] n5,
  output logic [PIX_W-1:0] n6,
  output logic [PIX_W-1:0] n7,
  output logic [PIX_W-1:0] n8,
  output logic [PIX_W-1:0] n9
`ifdef JANELA_FIM_QUADRO_EN
  ,
  output logic             fim_quadro
`endif
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [PIX_W-1:0] win_q [WIN_N];
  logic [PIX_W-1:0] win_d [WIN_N];
  logic [PIX_W-1:0] line_a, line_b;
  logic last_col, last_row, win_valid_q, win_valid_d, en;
  assign en = pix_valid && rst_n;
  assign last_col = col_q == CW'(IMG_W - 1);
  assign last_row = row_q == RW'(IMG_H - 1);
  linha_atraso #(.IMG_W(IMG_W), .PIX_W(PIX_W)) u_linha_a (
    .clk(clk), .en_i(en), .d_i(pix_in), .q_o(line_a)
  );
  linha_atraso #(.IMG_W(IMG_W), .PIX_W(PIX_W)) u_linha_b (
    .clk(clk), .en_i(en), .d_i(line_a), .q_o(line_b)
  );
  // next counter position, left-shifted window with the new right column, and validity of this pixel's window
  always_comb begin
    col_d = last_col ? '0 : col_q + 1'b1;
    row_d = last_col ? (last_row ? '0 : row_q + 1'b1) : row_q;
    for (int r = 0; r < 3; r++) begin
      win_d[3*r]   = win_q[3*r+1];
      win_d[3*r+1] = win_q[3*r+2];
    end
    win_d[2] = line_b;
    win_d[5] = line_a;
    win_d[8] = pix_in;
    win_valid_d = pix_valid && row_q >= RW'(2) && col_q >= CW'(2);
  end
  // state advances only on accepted pixels; the valid pulse is re-evaluated every cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col_q <= '0;
      row_q <= '0;
      win_q <= '{default: '0};
      win_valid_q <= 1'b0;
    end else begin
      win_valid_q <= win_valid_d;
      if (pix_valid) begin
        col_q <= col_d;
        row_q <= row_d;
        win_q <= win_d;
      end
    end
  end
`ifdef JANELA_FIM_QUADRO_EN
  logic fim_q;
  // flags the window of the last pixel of the frame
  always_ff @(posedge clk) begin
    if (!rst_n) fim_q <= 1'b0;
    else fim_q <= pix_valid && last_col && last_row;
  end
  assign fim_quadro = fim_q;
`endif
  assign win_valid = win_valid_q;
  assign n1 = win_q[0];
  assign n2 = win_q[1];
  assign n3 = win_q[2];
  assign n4 = win_q[3];
  assign n5 = win_q[4];
  assign n6 = win_q[5];
  assign n7 = win_q[6];
  assign n8 = win_q[7];
  assign n9 = win_q[8];
endmodule

// File: tb/tb_janela_3x3.sv
// tb_janela_3x3: directed checks of the 3x3 window generator on a 4x4 image
module tb_janela_3x3;
  import janela_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pix_valid = 1'b0;
  logic [8:0] pix_in = '0;
  logic win_valid;
  logic [8:0] n1, n2, n3, n4, n5, n6, n7, n8, n9;
`ifdef JANELA_FIM_QUADRO_EN
  logic fim_quadro;
`endif
  janela_t cur;
  janela_t wq[$];
  int checks = 0;
  int errors = 0;
  int idle_bad = 0;
  int fim_n = 0;
  int fim_bad = 0;
  logic [8:0] fim_n9 = '0;
  logic prev_acc = 1'b0;

  always #5 clk = ~clk;

  janela_3x3 #(.PIX_W(9), .IMG_W(4), .IMG_H(4)) dut (
    .clk(clk), .rst_n(rst_n), .pix_valid(pix_valid), .pix_in(pix_in),
    .win_valid(win_valid),
    .n1(n1), .n2(n2), .n3(n3), .n4(n4), .n5(n5), .n6(n6), .n7(n7), .n8(n8), .n9(n9)
`ifdef JANELA_FIM_QUADRO_EN
    , .fim_quadro(fim_quadro)
`endif
  );

  assign cur = {n1, n2, n3, n4, n5, n6, n7, n8, n9};

  always @(posedge clk) prev_acc <= pix_valid && rst_n;

  always @(negedge clk) begin
    if (win_valid === 1'b1) begin
      wq.push_back(cur);
      if (!prev_acc) idle_bad++;
    end
`ifdef JANELA_FIM_QUADRO_EN
    if (fim_quadro === 1'b1) begin
      fim_n++;
      fim_n9 = n9;
      if (win_valid !== 1'b1) fim_bad++;
    end
`endif
  end

  function automatic janela_t mk(input int t, input bit alt);
    int off [9] = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
    janela_t w;
    for (int i = 0; i < 9; i++) w[i] = alt ? ((t + off[i]) % 2 == 1 ? 9'd511 : 9'd0) : 9'(t + off[i]);
    return w;
  endfunction

  task automatic push(input int v);
    pix_valid = 1'b1;
    pix_in = 9'(v);
    @(negedge clk);
  endtask

  task automatic idle();
    pix_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic clear();
    wq.delete();
    idle_bad = 0;
    fim_n = 0;
    fim_bad = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    pix_valid = 1'b1;
    pix_in = 9'd99;
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    clear();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    pix_valid = 1'b1;
    pix_in = 9'd5;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (win_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", win_valid); end
    checks++;
    if (cur !== janela_t'(0)) begin errors++; $display("FAIL reset_window got %h exp 0", cur); end
    rst_n = 1'b1;
    idle();
    checks++;
    if (win_valid !== 1'b0) begin errors++; $display("FAIL post_reset_valid got %b exp 0", win_valid); end
    clear();
  endtask

  task automatic test_continuous();
    int exp9 [4] = '{10, 11, 14, 15};
    do_reset();
    for (int i = 0; i < 16; i++) push(i);
    idle();
    checks++;
    if (wq.size() != 4) begin errors++; $display("FAIL cont_count got %0d exp 4", wq.size()); end
    else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (wq[k][8] !== 9'(exp9[k])) begin errors++; $display("FAIL cont_n9_%0d got %0d exp %0d", k, wq[k][8], exp9[k]); end
      end
      checks++;
      if (wq[0] !== mk(0, 0)) begin errors++; $display("FAIL cont_first got %h exp %h", wq[0], mk(0, 0)); end
      checks++;
      if (wq[3] !== mk(5, 0)) begin errors++; $display("FAIL cont_last got %h exp %h", wq[3], mk(5, 0)); end
    end
    idle();
    checks++;
    if (cur !== mk(5, 0) || win_valid !== 1'b0) begin errors++; $display("FAIL cont_hold got %h/%b exp %h/0", cur, win_valid, mk(5, 0)); end
`ifdef JANELA_FIM_QUADRO_EN
    checks++;
    if (fim_n != 1 || fim_bad != 0 || fim_n9 !== 9'd15) begin errors++; $display("FAIL fim_cont got %0d/%0d/%0d exp 1/0/15", fim_n, fim_bad, fim_n9); end
`endif
  endtask

  task automatic test_toggle();
    int exp9 [4] = '{10, 11, 14, 15};
    do_reset();
    for (int i = 0; i < 16; i++) begin
      push(i);
      idle();
    end
    idle();
    checks++;
    if (wq.size() != 4) begin errors++; $display("FAIL tog_count got %0d exp 4", wq.size()); end
    else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (wq[k][8] !== 9'(exp9[k])) begin errors++; $display("FAIL tog_n9_%0d got %0d exp %0d", k, wq[k][8], exp9[k]); end
      end
      checks++;
      if (wq[0] !== mk(0, 0)) begin errors++; $display("FAIL tog_first got %h exp %h", wq[0], mk(0, 0)); end
      checks++;
      if (wq[3] !== mk(5, 0)) begin errors++; $display("FAIL tog_last got %h exp %h", wq[3], mk(5, 0)); end
    end
    checks++;
    if (idle_bad != 0) begin errors++; $display("FAIL tog_after_idle got %0d exp 0", idle_bad); end
  endtask

  task automatic test_back_to_back();
    int exp9 [8] = '{10, 11, 14, 15, 26, 27, 30, 31};
    do_reset();
    for (int i = 0; i < 32; i++) push(i);
    idle();
    checks++;
    if (wq.size() != 8) begin errors++; $display("FAIL b2b_count got %0d exp 8", wq.size()); end
    else begin
      for (int k = 0; k < 8; k++) begin
        checks++;
        if (wq[k][8] !== 9'(exp9[k])) begin errors++; $display("FAIL b2b_n9_%0d got %0d exp %0d", k, wq[k][8], exp9[k]); end
      end
      checks++;
      if (wq[4] !== mk(16, 0)) begin errors++; $display("FAIL b2b_frame2_first got %h exp %h", wq[4], mk(16, 0)); end
    end
`ifdef JANELA_FIM_QUADRO_EN
    checks++;
    if (fim_n != 2 || fim_bad != 0) begin errors++; $display("FAIL fim_b2b got %0d/%0d exp 2/0", fim_n, fim_bad); end
`endif
  endtask

  task automatic test_reset_mid();
    int exp9 [4] = '{110, 111, 114, 115};
    do_reset();
    for (int i = 0; i < 7; i++) push(i);
    do_reset();
    for (int i = 100; i < 116; i++) push(i);
    idle();
    checks++;
    if (wq.size() != 4) begin errors++; $display("FAIL mid_count got %0d exp 4", wq.size()); end
    else begin
      checks++;
      if (wq[0] !== mk(100, 0)) begin errors++; $display("FAIL mid_first got %h exp %h", wq[0], mk(100, 0)); end
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (wq[k][8] !== 9'(exp9[k])) begin errors++; $display("FAIL mid_n9_%0d got %0d exp %0d", k, wq[k][8], exp9[k]); end
      end
    end
  endtask

  task automatic test_max();
    janela_t ones;
    ones = '1;
    do_reset();
    for (int i = 0; i < 16; i++) push(511);
    idle();
    checks++;
    if (wq.size() != 4) begin errors++; $display("FAIL max_count got %0d exp 4", wq.size()); end
    else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (wq[k] !== ones) begin errors++; $display("FAIL max_win_%0d got %h exp %h", k, wq[k], ones); end
      end
    end
    do_reset();
    for (int i = 0; i < 16; i++) push(i % 2 == 1 ? 511 : 0);
    idle();
    checks++;
    if (wq.size() != 4) begin errors++; $display("FAIL alt_count got %0d exp 4", wq.size()); end
    else begin
      checks++;
      if (wq[0] !== mk(0, 1)) begin errors++; $display("FAIL alt_first got %h exp %h", wq[0], mk(0, 1)); end
      checks++;
      if (wq[3] !== mk(5, 1)) begin errors++; $display("FAIL alt_last got %h exp %h", wq[3], mk(5, 1)); end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_continuous();
    test_toggle();
    test_back_to_back();
    test_reset_mid();
    test_max();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/janela_3x3.md
# janela_3x3

Streaming 3x3 window generator for the median filter. Accepts a raster-order pixel stream, one pixel per accepted cycle, and buffers the two previous image lines. For each pixel at row ≥ 2 and column ≥ 2 it presents the nine pixels of the 3x3 neighbourhood whose bottom-right corner is that pixel. It sits directly upstream of `ordena_9_num`, and its nine outputs map one-to-one onto the sorter's nine inputs.

## Interface
- `PIX_W`, default 9: pixel width in bits, matching the sorter data width.
- `IMG_W`, default 16: pixels per line, minimum 3.
- `IMG_H`, default 16: lines per frame, minimum 3.

- `clk`  in  1: single clock; all activity on the rising edge.
- `rst_n`  in  1: synchronous, active-low reset.
- `pix_valid`  in  1: `pix_in` is valid this cycle; the pixel is accepted at the rising edge.
- `pix_in`  in  PIX_W: incoming pixel, raster order.
- `win_valid`  out  1: window outputs hold a complete window; one-cycle pulse per window.
- `n1`..`n9`  out  PIX_W each: window in raster order.
  - `n1` to `n3`: top row, left to right.
  - `n4` to `n6`: middle row.
  - `n7` to `n9`: bottom row; `n9` is the newest pixel.

## Operation
- Column counter `col` runs 0..IMG_W-1 and row counter `row` runs 0..IMG_H-1.
  - Both advance only on accepted pixels.
  - `col` wraps to 0 and increments `row`.
  - After pixel (IMG_H-1, IMG_W-1), both wrap to 0; the next pixel starts a new frame.
- Line buffers: two delay lines of IMG_W pixels each, advancing only on accepted pixels.
  - Delay line A output is the pixel one line above `pix_in`.
  - Delay line B, fed from A's output, gives the pixel two lines above.
- Window register: 3x3 array that shifts left on every accepted pixel.
  - New right column: top = line B output, middle = line A output, bottom = `pix_in`.
- `win_valid` is registered as (pix_valid && row ≥ 2 && col ≥ 2), evaluated on the counters before increment.
- Windows crossing a line or frame boundary are never flagged valid, so no border handling is needed.
- Exactly (IMG_H-2)*(IMG_W-2) valid windows are produced per frame.
- When `pix_valid` = 0: nothing shifts, counters hold, `win_valid` = 0, and `n1`..`n9` hold their values.
- Counter widths are $clog2(IMG_W) and $clog2(IMG_H). Comparisons against IMG_W-1 and IMG_H-1 are exact, so no out-of-range values occur.

## Timing
- Latency is 1 cycle: the pixel accepted at edge k produces its window on `n1`..`n9` with `win_valid` = 1 during the cycle after edge k.
- Throughput: one window per accepted pixel; no backpressure.
- Reset values: `win_valid` = 0, `n1`..`n9` = 0, `col` = `row` = 0.
  - Line buffer contents are not cleared; they are don't-care because validity is gated by the counters.
- Reset mid-frame: the next accepted pixel is treated as (0,0) of a new frame.
- `rst_n` low with `pix_valid` high at the same edge: reset wins and the pixel is dropped.

## Configuration
- `JANELA_FIM_QUADRO_EN` defined:
  - Adds output `fim_quadro` (1 bit, reset 0).
  - `fim_quadro` pulses high for one cycle, aligned with `win_valid`, for the window of pixel (IMG_H-1, IMG_W-1).
- Undefined: the port and its logic are absent; all other behaviour is identical.

## Structure
- Package `janela_pkg` holds:
  - `PIX_W` default constant.
  - `pixel_t` (logic [PIX_W-1:0]).
  - `janela_t` (pixel_t [0:8]).
- Sub-module `linha_atraso`: parameterised IMG_W-deep, PIX_W-wide delay line with an enable. It is instantiated twice, for line buffers A and B.

## Test plan
All scenarios use IMG_W=4, IMG_H=4, PIX_W=9.
- Continuous pixels 0..15:
  - `win_valid` pulses 4 times, after pixels 10, 11, 14 and 15.
  - First window is 0 1 2 / 4 5 6 / 8 9 10.
  - Last window is 5 6 7 / 9 10 11 / 13 14 15.
- Same stream with `pix_valid` toggling every cycle: identical window sequence, and `win_valid` is never high in the cycle after an idle cycle.
- Two back-to-back frames, pixels 0..31:
  - No valid window for pixels 16..25.
  - Window at pixel 26 is 16 17 18 / 20 21 22 / 24 25 26.
  - Exactly 8 windows in total.
- Reset after pixel 6, then pixels 100..115:
  - The first window follows the 11th post-reset pixel: 100 101 102 / 104 105 106 / 108 109 110.
- Max-value pixels: all 511 gives window all 511; the pattern 0/511 alternating checks no bit truncation.
- With `JANELA_FIM_QUADRO_EN`: `fim_quadro` pulses exactly once per frame, coincident with the window ending at pixel 15.
